// File: rtl/acq_sweep_ctrl.sv
// acq_sweep_ctrl: sequences a full Doppler x code-shift acquisition search.
// For every cell it commands a code seek, plays the stored frame once,
// collects the early/prompt/late I2Q2 results and tracks the running peak.
module acq_sweep_ctrl #(
  parameter int                    DOPP_WIDTH   = 16,
  parameter int                    CS_WIDTH     = 11,
  parameter int                    I2Q2_WIDTH   = 32,
  parameter logic [DOPP_WIDTH-1:0] DOPP_BIN_INC = 16'd100,
  parameter int                    CS_MAX       = 2045,
  parameter int                    CS_STEP      = 1,
  parameter int                    SEEK_TIMEOUT = 4095
) (
  input  logic                  clk,
  input  logic                  global_reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [4:0]            prn_cfg,
  input  logic [DOPP_WIDTH-1:0] dopp_min,
  input  logic [DOPP_WIDTH-1:0] dopp_max,
  output logic [4:0]            prn,
  output logic [DOPP_WIDTH-1:0] doppler,
  output logic                  seek_en,
  output logic [CS_WIDTH-1:0]   seek_target,
  input  logic [CS_WIDTH-1:0]   code_shift,
  output logic                  playback_start,
  input  logic                  i2q2_valid,
  input  logic [I2Q2_WIDTH-1:0] i2q2_early,
  input  logic [I2Q2_WIDTH-1:0] i2q2_prompt,
  input  logic [I2Q2_WIDTH-1:0] i2q2_late,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [I2Q2_WIDTH-1:0] peak_i2q2,
  output logic [DOPP_WIDTH-1:0] peak_doppler,
  output logic [CS_WIDTH-1:0]   peak_code_shift,
  output logic [15:0]           pass_count
);

  localparam int                           TO_W    = $clog2(SEEK_TIMEOUT + 1);
  localparam logic [TO_W-1:0]              TO_MAX  = TO_W'(SEEK_TIMEOUT);
  localparam logic [CS_WIDTH:0]            CS_INC  = (CS_WIDTH+1)'(CS_STEP);
  localparam logic [CS_WIDTH:0]            CS_LAST = (CS_WIDTH+1)'(CS_MAX);
  localparam logic signed [DOPP_WIDTH:0]   ROW_INC = (DOPP_WIDTH+1)'(3 * DOPP_BIN_INC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEEK,
    S_WAIT_SEEK,
    S_PLAY,
    S_WAIT_RESULT,
    S_ADVANCE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                  r_state;
  logic [4:0]              r_prn;
  logic [DOPP_WIDTH-1:0]   r_doppler;
  logic                    r_seek_en;
  logic [CS_WIDTH-1:0]     r_seek_target;
  logic                    r_playback_start;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_error;
  logic [I2Q2_WIDTH-1:0]   r_peak_i2q2;
  logic [DOPP_WIDTH-1:0]   r_peak_doppler;
  logic [CS_WIDTH-1:0]     r_peak_code_shift;
  logic [15:0]             r_pass_count;
  logic [TO_W-1:0]         r_to_cnt;
  logic [I2Q2_WIDTH-1:0]   r_early;
  logic [I2Q2_WIDTH-1:0]   r_prompt;
  logic [I2Q2_WIDTH-1:0]   r_late;

  logic [I2Q2_WIDTH-1:0]        w_best;
  logic [DOPP_WIDTH-1:0]        w_best_dopp;
  logic [CS_WIDTH:0]            w_cs_next;
  logic                         w_cs_wrap;
  logic signed [DOPP_WIDTH:0]   w_dopp_next;
  logic signed [DOPP_WIDTH:0]   w_dopp_max_ext;
  logic                         w_dopp_ovf;
  logic                         w_row_done;

  // Per-pass best bin and next-cell arithmetic, evaluated from registered results
  always_comb begin
    w_best      = r_prompt;
    w_best_dopp = r_doppler;
    if (r_early > w_best) begin
      w_best      = r_early;
      w_best_dopp = r_doppler + DOPP_BIN_INC;
    end
    if (r_late > w_best) begin
      w_best      = r_late;
      w_best_dopp = r_doppler - DOPP_BIN_INC;
    end
    // one extra bit keeps the code-shift and Doppler steps from wrapping silently
    w_cs_next      = {1'b0, r_seek_target} + CS_INC;
    w_cs_wrap      = (w_cs_next > CS_LAST);
    w_dopp_next    = {r_doppler[DOPP_WIDTH-1], r_doppler} + ROW_INC;
    w_dopp_max_ext = {dopp_max[DOPP_WIDTH-1], dopp_max};
    w_dopp_ovf     = (w_dopp_next[DOPP_WIDTH] != w_dopp_next[DOPP_WIDTH-1]);
    w_row_done     = w_dopp_ovf || (w_dopp_next > w_dopp_max_ext);
  end

  // Sweep sequencer with registered outputs; abort overrides every state
  always_ff @(posedge clk or posedge global_reset) begin
    if (global_reset) begin
      r_state           <= S_IDLE;
      r_prn             <= '0;
      r_doppler         <= '0;
      r_seek_en         <= 1'b0;
      r_seek_target     <= '0;
      r_playback_start  <= 1'b0;
      r_busy            <= 1'b0;
      r_done            <= 1'b0;
      r_error           <= 1'b0;
      r_peak_i2q2       <= '0;
      r_peak_doppler    <= '0;
      r_peak_code_shift <= '0;
      r_pass_count      <= '0;
      r_to_cnt          <= '0;
      r_early           <= '0;
      r_prompt          <= '0;
      r_late            <= '0;
    end else begin
      // strobes are high only while in SEEK / PLAY respectively
      r_seek_en        <= 1'b0;
      r_playback_start <= 1'b0;
      if (abort) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
        r_done  <= 1'b0;
        r_error <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
              r_prn             <= prn_cfg;
              r_doppler         <= dopp_min;
              r_seek_target     <= '0;
              r_peak_i2q2       <= '0;
              r_peak_doppler    <= '0;
              r_peak_code_shift <= '0;
              r_pass_count      <= '0;
              r_done            <= 1'b0;
              r_error           <= 1'b0;
              r_busy            <= 1'b1;
              r_seek_en         <= 1'b1;
              r_state           <= S_SEEK;
            end
          end
          S_SEEK: begin
            r_to_cnt <= '0;
            r_state  <= S_WAIT_SEEK;
          end
          S_WAIT_SEEK: begin
            if (code_shift == r_seek_target) begin
              r_playback_start <= 1'b1;
              r_state          <= S_PLAY;
            end else if (r_to_cnt == TO_MAX) begin
              r_busy  <= 1'b0;
              r_error <= 1'b1;
              r_state <= S_ERROR;
            end else begin
              r_to_cnt <= r_to_cnt + TO_W'(1);
            end
          end
          S_PLAY: begin
            r_state <= S_WAIT_RESULT;
          end
          S_WAIT_RESULT: begin
            if (i2q2_valid) begin
              r_early  <= i2q2_early;
              r_prompt <= i2q2_prompt;
              r_late   <= i2q2_late;
              r_state  <= S_ADVANCE;
            end
          end
          S_ADVANCE: begin
            if (w_best > r_peak_i2q2) begin
              r_peak_i2q2       <= w_best;
              r_peak_doppler    <= w_best_dopp;
              r_peak_code_shift <= r_seek_target;
            end
            if (r_pass_count != 16'hFFFF) begin
              r_pass_count <= r_pass_count + 16'd1;
            end
            if (!w_cs_wrap) begin
              r_seek_target <= w_cs_next[CS_WIDTH-1:0];
              r_seek_en     <= 1'b1;
              r_state       <= S_SEEK;
            end else begin
              r_seek_target <= '0;
              if (w_row_done) begin
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_doppler <= w_dopp_next[DOPP_WIDTH-1:0];
                r_seek_en <= 1'b1;
                r_state   <= S_SEEK;
              end
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign prn             = r_prn;
  assign doppler         = r_doppler;
  assign seek_en         = r_seek_en;
  assign seek_target     = r_seek_target;
  assign playback_start  = r_playback_start;
  assign busy            = r_busy;
  assign done            = r_done;
  assign error           = r_error;
  assign peak_i2q2       = r_peak_i2q2;
  assign peak_doppler    = r_peak_doppler;
  assign peak_code_shift = r_peak_code_shift;
  assign pass_count      = r_pass_count;

endmodule

// File: tb/tb_acq_sweep_ctrl.sv
// Directed bench for acq_sweep_ctrl with a small behavioural channel model.
module tb_acq_sweep_ctrl;

  logic        clk;
  logic        global_reset;
  logic        start;
  logic        abort;
  logic [4:0]  prn_cfg;
  logic [15:0] dopp_min;
  logic [15:0] dopp_max;
  logic [4:0]  prn;
  logic [15:0] doppler;
  logic        seek_en;
  logic [10:0] seek_target;
  logic [10:0] code_shift;
  logic        playback_start;
  logic        i2q2_valid;
  logic [31:0] i2q2_early;
  logic [31:0] i2q2_prompt;
  logic [31:0] i2q2_late;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] peak_i2q2;
  logic [15:0] peak_doppler;
  logic [10:0] peak_code_shift;
  logic [15:0] pass_count;

  int total = 0;
  int bad   = 0;

  // channel model state
  int mode = 0;          // 0 zeros, 1..4 result patterns, 5 seek never matches
  int sdly, vdly, s_tgt, v_d, v_cs;
  int pb_cnt  = 0;
  int log_n   = 0;
  int overlap = 0;
  int log_d  [256];
  int log_cs [256];

  acq_sweep_ctrl #(
    .CS_MAX  (5),
    .CS_STEP (2)
  ) dut (
    .clk             (clk),
    .global_reset    (global_reset),
    .start           (start),
    .abort           (abort),
    .prn_cfg         (prn_cfg),
    .dopp_min        (dopp_min),
    .dopp_max        (dopp_max),
    .prn             (prn),
    .doppler         (doppler),
    .seek_en         (seek_en),
    .seek_target     (seek_target),
    .code_shift      (code_shift),
    .playback_start  (playback_start),
    .i2q2_valid      (i2q2_valid),
    .i2q2_early      (i2q2_early),
    .i2q2_prompt     (i2q2_prompt),
    .i2q2_late       (i2q2_late),
    .busy            (busy),
    .done            (done),
    .error           (error),
    .peak_i2q2       (peak_i2q2),
    .peak_doppler    (peak_doppler),
    .peak_code_shift (peak_code_shift),
    .pass_count      (pass_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Channel model: echoes seek_target 3 cycles after seek_en, returns results 4 cycles after playback
  initial begin
    code_shift = '0; i2q2_valid = 1'b0;
    i2q2_early = '0; i2q2_prompt = '0; i2q2_late = '0;
    sdly = 0; vdly = 0; s_tgt = 0; v_d = 0; v_cs = 0;
    forever begin
      @(negedge clk);
      if (seek_en && playback_start) overlap++;
      if (mode == 5) begin
        code_shift = 11'd7;
        sdly = 0;
      end else if (sdly > 0) begin
        sdly--;
        if (sdly == 0) code_shift = 11'(s_tgt);
      end
      if (seek_en) begin
        sdly  = 3;
        s_tgt = int'(seek_target);
      end
      i2q2_valid = 1'b0;
      if (vdly > 0) begin
        vdly--;
        if (vdly == 0) begin
          i2q2_valid = 1'b1;
          i2q2_early = '0; i2q2_prompt = '0; i2q2_late = '0;
          case (mode)
            1: if (v_d == -300 && v_cs == 2) i2q2_early = 32'd500;
            2: if (v_d == -300 && (v_cs == 0 || v_cs == 4)) i2q2_prompt = 32'd700;
            3: if (v_d == -300 && v_cs == 2) begin
                 i2q2_early = 32'd700; i2q2_prompt = 32'd700; i2q2_late = 32'd700;
               end
            4: if (v_d == 0 && v_cs == 4) begin
                 i2q2_early = 32'd300; i2q2_late = 32'd900;
               end
            default: ;
          endcase
        end
      end
      if (playback_start) begin
        vdly = 4;
        v_d  = int'($signed(doppler));
        v_cs = int'(seek_target);
        if (log_n < 256) begin
          log_d[log_n]  = v_d;
          log_cs[log_n] = v_cs;
        end
        log_n++;
        pb_cnt++;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // Pulse start at a negedge and wait (bounded) for done or error
  task automatic run_sweep(input int m, output int base);
    int cyc;
    mode = m;
    base = log_n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", 64'(busy), 64'(1));
    cyc = 0;
    while (!(done || error) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("sweep_end", 64'(done | error), 64'(1));
  endtask

  int base;
  int cyc;
  int pb0;
  int exp_d  [6] = '{-300, -300, -300, 0, 0, 0};
  int exp_cs [6] = '{0, 2, 4, 0, 2, 4};

  initial begin
    global_reset = 1'b1;
    start = 1'b0; abort = 1'b0;
    prn_cfg = 5'd17;
    dopp_min = -16'sd300;
    dopp_max = 16'sd0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_prn", 64'(prn), 64'(0));
    check("rst_pass", 64'(pass_count), 64'(0));
    global_reset = 1'b0;
    @(negedge clk);
    check("idle_done", 64'({done, error, seek_en, playback_start}), 64'(0));

    // all-zero sweep: sequence of cells, done, pass_count 6
    mode = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t1_seek_en", 64'(seek_en), 64'(1));
    check("t1_prn", 64'(prn), 64'(17));
    check("t1_dopp", 64'($signed(doppler)), -64'sd300);
    base = log_n;
    cyc = 0;
    while (!done && cyc < 2000) begin @(negedge clk); cyc++; end
    check("t1_done", 64'(done), 64'(1));
    check("t1_busy", 64'(busy), 64'(0));
    check("t1_pass", 64'(pass_count), 64'(6));
    check("t1_peak", 64'(peak_i2q2), 64'(0));
    check("t1_dopp_last", 64'($signed(doppler)), 64'(0));
    check("t1_tgt", 64'(seek_target), 64'(0));
    check("t1_npass", 64'(log_n - base), 64'(6));
    for (int i = 0; i < 6; i++) begin
      check("t1_cell_d", 64'(log_d[base+i]), 64'(exp_d[i]));
      check("t1_cell_cs", 64'(log_cs[base+i]), 64'(exp_cs[i]));
    end

    // early bin wins at (-300, 2)
    run_sweep(1, base);
    check("t2_peak", 64'(peak_i2q2), 64'(500));
    check("t2_pdop", 64'($signed(peak_doppler)), -64'sd200);
    check("t2_pcs", 64'(peak_code_shift), 64'(2));
    check("t2_pass", 64'(pass_count), 64'(6));

    // tie across cells keeps the earlier one
    run_sweep(2, base);
    check("t3_peak", 64'(peak_i2q2), 64'(700));
    check("t3_pcs", 64'(peak_code_shift), 64'(0));
    check("t3_pdop", 64'($signed(peak_doppler)), -64'sd300);

    // equal early/prompt/late keeps prompt Doppler
    run_sweep(3, base);
    check("t3b_pdop", 64'($signed(peak_doppler)), -64'sd300);
    check("t3b_pcs", 64'(peak_code_shift), 64'(2));

    // late beats early within a pass
    run_sweep(4, base);
    check("t3c_peak", 64'(peak_i2q2), 64'(900));
    check("t3c_pdop", 64'($signed(peak_doppler)), -64'sd100);
    check("t3c_pcs", 64'(peak_code_shift), 64'(4));

    // dopp_min above dopp_max: one row, then done
    dopp_min = 16'sd100;
    dopp_max = -16'sd100;
    run_sweep(0, base);
    check("t7_pass", 64'(pass_count), 64'(3));
    check("t7_dopp", 64'($signed(doppler)), 64'(100));
    dopp_min = -16'sd300;
    dopp_max = 16'sd0;

    // seek never completes: error after 4096 WAIT_SEEK cycles
    mode = 5;
    @(negedge clk);
    pb0 = pb_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t4_seek_en", 64'(seek_en), 64'(1));
    cyc = 0;
    while (!error && cyc < 5000) begin @(negedge clk); cyc++; end
    check("t4_cycles", 64'(cyc), 64'(4097));
    check("t4_error", 64'(error), 64'(1));
    check("t4_busy", 64'(busy), 64'(0));
    check("t4_done", 64'(done), 64'(0));
    check("t4_noplay", 64'(pb_cnt - pb0), 64'(0));

    // abort in WAIT_RESULT of the third pass
    mode = 1;
    pb0 = pb_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t5_err_clr", 64'(error), 64'(0));
    cyc = 0;
    while (pb_cnt < pb0 + 3 && cyc < 500) begin @(negedge clk); cyc++; end
    check("t5_reach", 64'(pb_cnt - pb0), 64'(3));
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t5_busy", 64'(busy), 64'(0));
    check("t5_done", 64'(done), 64'(0));
    check("t5_pass", 64'(pass_count), 64'(2));
    check("t5_peak", 64'(peak_i2q2), 64'(500));
    repeat (8) @(negedge clk);
    check("t5_ignored", 64'(pass_count), 64'(2));
    check("t5_idle", 64'({busy, seek_en, playback_start}), 64'(0));

    // start together with abort: abort wins
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("t5_sa_busy", 64'(busy), 64'(0));
    check("t5_sa_pass", 64'(pass_count), 64'(2));

    // a fresh start clears the peak and pass counter
    prn_cfg = 5'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t5_new_pass", 64'(pass_count), 64'(0));
    check("t5_new_peak", 64'(peak_i2q2), 64'(0));
    check("t5_new_prn", 64'(prn), 64'(9));

    // asynchronous reset while in PLAY
    cyc = 0;
    while (!playback_start && cyc < 500) begin @(negedge clk); cyc++; end
    check("t6_play", 64'(playback_start), 64'(1));
    #2 global_reset = 1'b1;
    #1;
    check("t6_async", 64'({busy, done, error, seek_en, playback_start}), 64'(0));
    check("t6_prn", 64'(prn), 64'(0));
    check("t6_dopp", 64'(doppler), 64'(0));
    check("t6_pcs", 64'({peak_i2q2, peak_doppler, peak_code_shift}), 64'(0));
    @(negedge clk);
    global_reset = 1'b0;
    repeat (10) @(negedge clk);
    check("t6_after", 64'({busy, pass_count}), 64'(0));

    check("no_overlap", 64'(overlap), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/acq_sweep_ctrl.md
Name: acq_sweep_ctrl

Overview:
Sequences a full acquisition search over the single-channel acquisition datapath (memory bank in playback mode plus channel with early/prompt/late Doppler bins). For each (Doppler, code-shift) cell it commands a code seek, triggers one playback of the stored frame, collects the three I2Q2 results, and keeps a running peak. Sits between the host/config logic and the acquisition top, driving its doppler, prn, seek_en and seek_target inputs.

Parameters:
DOPP_WIDTH, 16, signed Doppler increment width.
CS_WIDTH, 11, code-shift width.
I2Q2_WIDTH, 32, I2Q2 magnitude width.
DOPP_BIN_INC, 16'd100, spacing between early/prompt/late bins. Each pass covers prompt-BIN, prompt, prompt+BIN.
CS_MAX, 2045, last legal code shift.
CS_STEP, 1, code-shift increment between passes.
SEEK_TIMEOUT, 4095, maximum cycles to wait for seek completion.

Ports:
clk  in  1  system clock
global_reset  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse; begins sweep (ignored unless IDLE/DONE/ERROR)
abort  in  1  level; returns to IDLE next cycle
prn_cfg  in  5  satellite PRN for this sweep
dopp_min  in  DOPP_WIDTH  signed prompt Doppler of first pass
dopp_max  in  DOPP_WIDTH  signed upper limit for prompt Doppler
prn  out  5  PRN to channel, latched on start
doppler  out  DOPP_WIDTH  prompt Doppler to channel
seek_en  out  1  seek request to channel
seek_target  out  CS_WIDTH  target code shift
code_shift  in  CS_WIDTH  current channel code shift
playback_start  out  1  one-cycle pulse requesting one frame playback
i2q2_valid  in  1  channel result strobe
i2q2_early/i2q2_prompt/i2q2_late  in  I2Q2_WIDTH each  pass results
busy  out  1  sweep in progress
done  out  1  sweep complete, held until next start or abort
error  out  1  seek timeout, held until next start or abort
peak_i2q2  out  I2Q2_WIDTH  best magnitude so far
peak_doppler  out  DOPP_WIDTH  Doppler of best bin
peak_code_shift  out  CS_WIDTH  code shift of best cell
pass_count  out  16  completed passes, saturating

Behaviour:
- Reset: state IDLE. All outputs 0, including prn, doppler, seek_target, peak_*, pass_count, busy, done, error, seek_en and playback_start.
- States: IDLE, SEEK, WAIT_SEEK, PLAY, WAIT_RESULT, ADVANCE, DONE, ERROR.
- IDLE/DONE/ERROR + start:
  - latch prn_cfg->prn, dopp_min->doppler; seek_target=0.
  - clear peak_*, pass_count, done, error.
  - busy=1; go to SEEK.
- SEEK: seek_en=1 for one cycle; load timeout counter=0; go to WAIT_SEEK.
- WAIT_SEEK: counter increments each cycle.
  - code_shift==seek_target -> PLAY.
  - counter==SEEK_TIMEOUT -> ERROR (busy=0, error=1).
  - Match wins if both occur in the same cycle.
- PLAY: playback_start=1 for exactly one cycle; go to WAIT_RESULT.
- WAIT_RESULT: on i2q2_valid, register the three results; go to ADVANCE. No timeout applies. Strobes outside WAIT_RESULT are ignored.
- ADVANCE (one cycle):
  - Pass best: start with prompt (doppler). If early > best, take early (doppler+DOPP_BIN_INC). Then if late > best, take late (doppler-DOPP_BIN_INC). All comparisons unsigned and strict.
  - If pass best > peak_i2q2 (strict), update peak_i2q2, peak_doppler and peak_code_shift=seek_target. Ties keep the earlier peak.
  - pass_count += 1, saturating at 16'hFFFF.
  - If seek_target+CS_STEP <= CS_MAX: seek_target += CS_STEP -> SEEK. Compute the sum at CS_WIDTH+1 bits to avoid wrap.
  - Else seek_target=0 and doppler += 3*DOPP_BIN_INC, using signed arithmetic at DOPP_WIDTH+1 bits.
    - Result > dopp_max or overflowed -> DONE (busy=0, done=1); doppler holds its last swept value.
    - Otherwise -> SEEK.
- abort: from any state, IDLE next cycle. Clears busy, seek_en and playback_start. Preserves peak_* and pass_count; done and error cleared.
- Simultaneous start and abort: abort wins.
- dopp_min > dopp_max at start: one Doppler row is still swept, then DONE.
- Outputs are registered; seek_en and playback_start never assert together.

Test Plan:
- CS_MAX=5, CS_STEP=2, dopp_min=-300, dopp_max=0, BIN_INC=100; channel model echoes seek_target to code_shift after 3 cycles and returns all-zero results. Expected: seek targets 0,2,4 at doppler=-300, then 0,2,4 at doppler=0; done=1; pass_count=6; peak_i2q2=0.
- Same config; model returns early=500 only at doppler=-300, cs=2. Expected: peak_i2q2=500, peak_doppler=-200, peak_code_shift=2.
- Equal values 700 at cs=0 and cs=4. Expected: peak_code_shift=0 (tie keeps earlier). Prompt=early=late=700 in one pass gives peak_doppler=prompt.
- Model never matches code_shift. Expected: after 4096 WAIT_SEEK cycles, error=1, busy=0, playback_start never pulsed.
- abort asserted in WAIT_RESULT after two passes. Expected: IDLE next cycle; pass_count=2 retained; done=0; a later start clears peak_* and pass_count.
- Reset asserted asynchronously mid-PLAY. Expected: all outputs 0 immediately; i2q2_valid after reset is ignored.
